// File: rtl/reset_sequencer_pf.sv
// Fabric reset sequencer for PolarFire designs.
// The block qualifies lock, init and system-service conditions through
// synchronisers and filters them. It then releases NUM_CH active-low resets
// in a fixed staggered order, bit 0 first. Lock loss or a software request
// asserts every reset again and restarts the full sequence.
module reset_sequencer_pf #(
    parameter int NUM_CH      = 4,
    parameter int NUM_LOCK    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FILTER = 16,
    parameter int STEP_DLY    = 8
) (
    input  logic                clk,
    input  logic                ext_rst_n,
    input  logic [NUM_LOCK-1:0] pll_lock,
    input  logic                init_done,
    input  logic                ss_busy,
    input  logic                ff_us_restore,
    input  logic                sw_rst_req,
    output logic [NUM_CH-1:0]   fabric_reset_n,
    output logic                seq_done,
    output logic                lock_lost,
    output logic [1:0]          state
);

    localparam int CNT_MAX = (LOCK_FILTER > STEP_DLY) ? LOCK_FILTER : STEP_DLY;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IN_W    = NUM_LOCK + 3;

    localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_DLY - 1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_FILTER  = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] bridge_q;
    logic                   rst_int_n;
    logic [IN_W-1:0]        sync_q [SYNC_STAGES];

    logic [NUM_LOCK-1:0] lock_s;
    logic                init_s;
    logic                busy_s;
    logic                ffr_s;
    logic                start_ok;
    logic                run_ok;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_CH-1:0]  rst_q, rst_d;
    logic               done_q, done_d;
    logic               lost_q, lost_d;

    // Reset bridge: assert asynchronously, release after SYNC_STAGES clocks.
    always_ff @(posedge clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            bridge_q <= '0;
        end else begin
            bridge_q <= {bridge_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_int_n = bridge_q[SYNC_STAGES-1];

    // Synchronise all asynchronous qualifiers as one bundle of flop chains.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= {ff_us_restore, ss_busy, init_done, pll_lock};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign lock_s   = sync_q[SYNC_STAGES-1][NUM_LOCK-1:0];
    assign init_s   = sync_q[SYNC_STAGES-1][NUM_LOCK];
    assign busy_s   = sync_q[SYNC_STAGES-1][NUM_LOCK+1];
    assign ffr_s    = sync_q[SYNC_STAGES-1][NUM_LOCK+2];

    // SS_BUSY and Flash*Freeze restore only gate the start; once running,
    // only the PLL locks can pull the resets back.
    assign start_ok = (&lock_s) & init_s & ~busy_s & ~ffr_s;
    assign run_ok   = &lock_s;

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            done_q  <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            lost_q  <= lost_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        done_d  = done_q;
        lost_d  = 1'b0;

        case (state_q)
            ST_HOLD: begin
                rst_d  = '0;
                done_d = 1'b0;
                cnt_d  = '0;
                idx_d  = '0;
                if (start_ok) begin
                    state_d = ST_FILTER;
                end
            end

            ST_FILTER: begin
                if (!start_ok || sw_rst_req) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == FILTER_LAST) begin
                    rst_d[0] = 1'b1;
                    cnt_d    = '0;
                    idx_d    = '0;
                    if (NUM_CH == 1) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RELEASE, ST_RUN: begin
                if (!run_ok || sw_rst_req) begin
                    state_d = ST_HOLD;
                    rst_d   = '0;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                    idx_d   = '0;
                    lost_d  = ~run_ok;
                end else if (state_q == ST_RELEASE) begin
                    if (cnt_q == STEP_LAST) begin
                        // Released bits form a contiguous run from bit 0, so
                        // shifting in a one releases exactly bit idx+1.
                        rst_d = (rst_q << 1) | NUM_CH'(1);
                        idx_d = idx_q + 1'b1;
                        cnt_d = '0;
                        if (int'(idx_q) + 2 == NUM_CH) begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_HOLD;
                rst_d   = '0;
                done_d  = 1'b0;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    assign fabric_reset_n = rst_q;
    assign seq_done       = done_q;
    assign lock_lost      = lost_q;
    assign state          = state_q;

endmodule

// File: tb/tb_reset_sequencer_pf.sv
// Self-checking bench for reset_sequencer_pf with default parameters.
module tb_reset_sequencer_pf;

    localparam int NCH = 4;
    localparam int NLK = 2;
    localparam int LF  = 16;
    localparam int SD  = 8;

    logic           clk = 1'b0;
    logic           ext_rst_n;
    logic [NLK-1:0] pll_lock;
    logic           init_done;
    logic           ss_busy;
    logic           ff_us_restore;
    logic           sw_rst_req;
    logic [NCH-1:0] fabric_reset_n;
    logic           seq_done;
    logic           lock_lost;
    logic [1:0]     state;

    typedef struct packed {
        logic [NCH-1:0] rst;
        logic           done;
        logic           lost;
        logic [1:0]     st;
    } out_t;

    typedef struct {
        logic [NLK-1:0] lock;
        logic           init;
        logic           busy;
        logic           ffr;
        out_t           exp;
        string          nm;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    out_t  exp_q[$];
    string nm_q[$];
    vec_t  tbl[5];
    out_t  run_o;
    out_t  zero_o;
    out_t  lost_o;

    always #5 clk = ~clk;

    reset_sequencer_pf #(
        .NUM_CH(NCH), .NUM_LOCK(NLK), .SYNC_STAGES(2), .LOCK_FILTER(LF), .STEP_DLY(SD)
    ) dut (
        .clk(clk),
        .ext_rst_n(ext_rst_n),
        .pll_lock(pll_lock),
        .init_done(init_done),
        .ss_busy(ss_busy),
        .ff_us_restore(ff_us_restore),
        .sw_rst_req(sw_rst_req),
        .fabric_reset_n(fabric_reset_n),
        .seq_done(seq_done),
        .lock_lost(lock_lost),
        .state(state)
    );

    // Expected outputs m cycles after the first HOLD cycle that sees start_ok.
    function automatic out_t exp_seq(input int m);
        out_t o;
        o = '0;
        if (m >= 1) o.st = 2'd1;
        if (m >= LF + 1) o.st = 2'd2;
        for (int i = 0; i < NCH; i++) begin
            if (m >= LF + 1 + SD * i) o.rst = o.rst | (NCH'(1) << i);
        end
        if (m >= LF + 1 + SD * (NCH - 1)) begin
            o.st   = 2'd3;
            o.done = 1'b1;
        end
        return o;
    endfunction

    function automatic out_t dut_out();
        return {fabric_reset_n, seq_done, lock_lost, state};
    endfunction

    task automatic check(input out_t got, input out_t want, input string nm);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got rst=%b done=%b lost=%b st=%0d, want rst=%b done=%b lost=%b st=%0d",
                     nm, got.rst, got.done, got.lost, got.st, want.rst, want.done, want.lost, want.st);
        end
    endtask

    // Push the expectation for the coming edge, then pop it against the DUT.
    task automatic cyc(input out_t want, input string nm);
        exp_q.push_back(want);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
        check(dut_out(), exp_q.pop_front(), nm_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        ext_rst_n     = 1'b0;
        pll_lock      = '0;
        init_done     = 1'b0;
        ss_busy       = 1'b0;
        ff_us_restore = 1'b0;
        sw_rst_req    = 1'b0;

        run_o  = exp_seq(1000);
        zero_o = '0;
        lost_o = '0;
        lost_o.lost = 1'b1;

        tbl[0] = '{lock: 2'b11, init: 1'b1, busy: 1'b1, ffr: 1'b0, exp: run_o, nm: "run_ss_busy"};
        tbl[1] = '{lock: 2'b11, init: 1'b1, busy: 1'b0, ffr: 1'b1, exp: run_o, nm: "run_ff_restore"};
        tbl[2] = '{lock: 2'b11, init: 1'b1, busy: 1'b1, ffr: 1'b1, exp: run_o, nm: "run_busy_and_ff"};
        tbl[3] = '{lock: 2'b11, init: 1'b0, busy: 1'b0, ffr: 0, exp: run_o, nm: "run_init_low"};
        tbl[4] = '{lock: 2'b11, init: 1'b1, busy: 1'b0, ffr: 1'b0, exp: run_o, nm: "run_idle"};

        // Reset state while EXT_RST_N is held low.
        for (int n = 1; n <= 3; n++) cyc(zero_o, $sformatf("reset_low_%0d", n));
        ext_rst_n = 1'b1;
        for (int n = 1; n <= 4; n++) cyc(zero_o, $sformatf("bridge_%0d", n));

        // Default start-up: bits at 19/27/35/43 from the pins going good.
        pll_lock  = 2'b11;
        init_done = 1'b1;
        for (int n = 1; n <= 46; n++) cyc(exp_seq(n - 2), $sformatf("startup_c%0d", n));

        // Qualifiers that must be ignored while running.
        for (int v = 0; v < 5; v++) begin
            pll_lock      = tbl[v].lock;
            init_done     = tbl[v].init;
            ss_busy       = tbl[v].busy;
            ff_us_restore = tbl[v].ffr;
            for (int n = 1; n <= 4; n++) cyc(tbl[v].exp, $sformatf("%s_%0d", tbl[v].nm, n));
        end

        // Lock loss in RUN: asserted 3 edges after the pin falls.
        pll_lock = 2'b10;
        for (int n = 1; n <= 5; n++)
            cyc((n < 3) ? run_o : ((n == 3) ? lost_o : zero_o), $sformatf("lockloss_c%0d", n));
        pll_lock = 2'b11;
        for (int n = 1; n <= 46; n++) cyc(exp_seq(n - 2), $sformatf("relock_c%0d", n));

        // SW request and lock loss sampled on the same edge.
        pll_lock = 2'b10;
        for (int n = 1; n <= 4; n++) begin
            sw_rst_req = (n == 3);
            cyc((n < 3) ? run_o : ((n == 3) ? lost_o : zero_o), $sformatf("sw_and_loss_c%0d", n));
        end
        // SW request in HOLD is ignored while start_ok holds.
        pll_lock = 2'b11;
        for (int n = 1; n <= 44; n++) begin
            sw_rst_req = (n == 3);
            cyc(exp_seq(n - 2), $sformatf("sw_in_hold_c%0d", n));
        end
        sw_rst_req = 1'b0;

        // SW request alone (no LOCK_LOST), then FF_US_RESTORE blocks start.
        ff_us_restore = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            sw_rst_req = (n == 4);
            cyc((n <= 3) ? run_o : zero_o, $sformatf("sw_alone_ff_c%0d", n));
        end
        sw_rst_req = 1'b0;

        // Release FF_US_RESTORE; glitch PLL_LOCK[1] for 3 cycles at FILTER cnt=10.
        ff_us_restore = 1'b0;
        for (int n = 1; n <= 63; n++) begin
            pll_lock = (n - 1 >= 13 && n - 1 <= 15) ? 2'b01 : 2'b11;
            cyc((n < 16) ? exp_seq(n - 2) : exp_seq(n - 18), $sformatf("filter_glitch_c%0d", n));
        end
        pll_lock = 2'b11;

        // Re-sequence to two released bits, then async reset mid-RELEASE.
        for (int n = 1; n <= 30; n++) begin
            sw_rst_req = (n == 1);
            cyc(exp_seq(n - 1), $sformatf("pre_async_c%0d", n));
        end
        sw_rst_req = 1'b0;
        ext_rst_n  = 1'b0;
        #1;
        check(dut_out(), zero_o, "async_clear_before_edge");
        #3;
        ext_rst_n = 1'b1;
        for (int n = 1; n <= 50; n++) cyc(exp_seq(n - 4), $sformatf("post_async_c%0d", n));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
